systolic_operand_feeder: RTL and testbench

SYSTOLIC_OPERAND_FEEDER -- requirements
Module: systolic_operand_feeder

---
 rtl/systolic_operand_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_operand_feeder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an ARRAY_SIZE systolic array. It streams k_len skewed A/B beats, flushes the array,
// launches requantisation and waits for its result. Define SYSTOLIC_FEEDER_TIMEOUT_EN to abort a stalled WAIT.
module systolic_operand_feeder #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K_MAX      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [$clog2(K_MAX+1)-1:0]           k_len,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] s_a,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] s_b,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_out,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_out,
  output logic                                 sys_enable,
  output logic                                 accum_clear,
  output logic                                 accum_enable,
  output logic                                 quant_enable,
  input  logic                                 quant_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int unsigned KW          = $clog2(K_MAX + 1);
  localparam int unsigned FLUSH_STEPS = 2 * ARRAY_SIZE - 1;
  localparam int unsigned FW          = $clog2(FLUSH_STEPS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_QUANT,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;

  logic k_ok_c;
  logic stream_c;
  logic step_c;
  logic last_beat_c;
  logic last_flush_c;
  logic timeout_c;

  logic s_ready_nxt;
  logic busy_nxt;
  logic accum_clear_nxt;
  logic sys_enable_nxt;
  logic accum_enable_nxt;
  logic quant_enable_nxt;
  logic done_nxt;
  logic err_nxt;

  assign k_ok_c       = (k_len != '0) && (32'(k_len) <= K_MAX);
  assign stream_c     = (state == ST_STREAM);
  // A step is an accepted beat while streaming, or every cycle of the zero-injecting flush.
  assign step_c       = (stream_c && s_valid && s_ready) || (state == ST_FLUSH);
  assign last_beat_c  = ((beat_cnt + KW'(1)) == k_lat);
  assign last_flush_c = (flush_cnt == FW'(FLUSH_STEPS - 1));

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt;

  // Cycles spent in WAIT so far; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timeout_c = (state == ST_WAIT) && !quant_valid && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start && k_ok_c) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_STREAM;
      ST_STREAM: if (step_c && last_beat_c) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (last_flush_c) state_nxt = ST_QUANT;
      ST_QUANT:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (quant_valid) begin
          state_nxt = ST_DONE;
        end else if (timeout_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: flags follow the state being entered so the registered copies line up with it.
  always_comb begin
    s_ready_nxt      = 1'b0;
    busy_nxt         = 1'b0;
    accum_clear_nxt  = 1'b0;
    sys_enable_nxt   = 1'b0;
    accum_enable_nxt = 1'b0;
    quant_enable_nxt = 1'b0;
    done_nxt         = 1'b0;
    err_nxt          = 1'b0;

    s_ready_nxt      = (state_nxt == ST_STREAM);
    busy_nxt         = (state_nxt != ST_IDLE);
    accum_clear_nxt  = (state_nxt == ST_CLEAR);
    quant_enable_nxt = (state_nxt == ST_QUANT);
    done_nxt         = (state_nxt == ST_DONE);
    sys_enable_nxt   = step_c;
    accum_enable_nxt = sys_enable;
    err_nxt          = ((state == ST_IDLE) && start && !k_ok_c) || timeout_c;
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      accum_clear  <= 1'b0;
      sys_enable   <= 1'b0;
      accum_enable <= 1'b0;
      quant_enable <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      s_ready      <= s_ready_nxt;
      busy         <= busy_nxt;
      accum_clear  <= accum_clear_nxt;
      sys_enable   <= sys_enable_nxt;
      accum_enable <= accum_enable_nxt;
      quant_enable <= quant_enable_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

  // Job length latch and beat/flush counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && start && k_ok_c) begin
        k_lat <= k_len;
      end
      if (state == ST_CLEAR) begin
        beat_cnt <= '0;
      end else if (stream_c && step_c) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (state != ST_FLUSH) begin
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt + FW'(1);
      end
    end
  end

  // Per-lane skew: lane i is delayed by i+1 step-qualified registers, zeros injected outside STREAM.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] pipe_a [i+1];
    logic [DATA_WIDTH-1:0] pipe_b [i+1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j <= i; j++) begin
          pipe_a[j] <= '0;
          pipe_b[j] <= '0;
        end
      end else if (step_c) begin
        pipe_a[0] <= stream_c ? s_a[i] : '0;
        pipe_b[0] <= stream_c ? s_b[i] : '0;
        for (int j = 1; j <= i; j++) begin
          pipe_a[j] <= pipe_a[j-1];
          pipe_b[j] <= pipe_b[j-1];
        end
      end
    end

    assign a_out[i] = pipe_a[i];
    assign b_out[i] = pipe_b[i];
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: a job-level reference model checked every cycle,
// plus hand-computed expectations for the headline scenarios.
module tb_systolic_operand_feeder;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int KM  = 16;
  localparam int KW  = $clog2(KM + 1);
  localparam int OW  = 8 + 2 * N * DW;

  localparam int P_IDLE   = 0;
  localparam int P_CLEAR  = 1;
  localparam int P_STREAM = 2;
  localparam int P_FLUSH  = 3;
  localparam int P_QUANT  = 4;
  localparam int P_WAIT   = 5;
  localparam int P_DONE   = 6;

  localparam int W_READY = 0;
  localparam int W_QEN   = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic s_valid = 1'b0;
  logic quant_valid = 1'b0;
  logic [N-1:0][DW-1:0] s_a = '0;
  logic [N-1:0][DW-1:0] s_b = '0;

  logic s_ready, sys_enable, accum_clear, accum_enable, quant_enable, busy, done, err;
  logic [N-1:0][DW-1:0] a_out, b_out;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_operand_feeder #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(DW),
    .K_MAX(KM)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .k_len(k_len),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_a(s_a),
    .s_b(s_b),
    .a_out(a_out),
    .b_out(b_out),
    .sys_enable(sys_enable),
    .accum_clear(accum_clear),
    .accum_enable(accum_enable),
    .quant_enable(quant_enable),
    .quant_valid(quant_valid),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int ph = P_IDLE;
  int m_k = 0;
  int m_steps = 0;
  int m_wait = 0;
  int md_j;
  logic m_step;
  logic [N-1:0][DW-1:0] beat_a [KM];
  logic [N-1:0][DW-1:0] beat_b [KM];
  logic e_ready = 0, e_busy = 0, e_clear = 0, e_sys = 0, e_acc = 0, e_qen = 0, e_done = 0, e_err = 0;
  logic [N-1:0][DW-1:0] e_a = '0;
  logic [N-1:0][DW-1:0] e_b = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = P_IDLE; m_k = 0; m_steps = 0; m_wait = 0;
      e_ready = 0; e_busy = 0; e_clear = 0; e_sys = 0; e_acc = 0; e_qen = 0; e_done = 0; e_err = 0;
      e_a = '0; e_b = '0;
    end else begin
      m_step = (ph == P_STREAM && s_valid) || (ph == P_FLUSH);
      e_acc = e_sys;
      e_sys = m_step;
      e_err = 0;
      if (ph == P_STREAM && s_valid) begin
        beat_a[m_steps] = s_a;
        beat_b[m_steps] = s_b;
      end
      if (m_step) m_steps++;
      case (ph)
        P_IDLE: if (start) begin
          if (int'(k_len) >= 1 && int'(k_len) <= KM) begin
            m_k = int'(k_len); m_steps = 0; ph = P_CLEAR;
          end else begin
            e_err = 1;
          end
        end
        P_CLEAR:  ph = P_STREAM;
        P_STREAM: if (m_steps == m_k) ph = P_FLUSH;
        P_FLUSH:  if (m_steps == m_k + 2 * N - 1) ph = P_QUANT;
        P_QUANT:  begin ph = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          if (quant_valid) begin
            ph = P_DONE;
          end else begin
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
            m_wait++;
            if (m_wait == 64) begin ph = P_IDLE; e_err = 1; end
`endif
          end
        end
        P_DONE:   ph = P_IDLE;
        default:  ph = P_IDLE;
      endcase
      e_ready = (ph == P_STREAM);
      e_busy  = (ph != P_IDLE);
      e_clear = (ph == P_CLEAR);
      e_qen   = (ph == P_QUANT);
      e_done  = (ph == P_DONE);
      // Lane i shows the beat accepted i steps before the latest one, zero outside the job's beats.
      for (int i = 0; i < N; i++) begin
        md_j = m_steps - 1 - i;
        e_a[i] = (md_j >= 0 && md_j < m_k) ? beat_a[md_j][i] : '0;
        e_b[i] = (md_j >= 0 && md_j < m_k) ? beat_b[md_j][i] : '0;
      end
    end
  end

  logic [OW-1:0] got_v, exp_v;
  assign got_v = {s_ready, busy, accum_clear, sys_enable, accum_enable, quant_enable, done, err, a_out, b_out};
  assign exp_v = {e_ready, e_busy, e_clear, e_sys, e_acc, e_qen, e_done, e_err, e_a, e_b};

  // ---------------- cycle compare and event counters ----------------
  int cyc = 0;
  int n_sys = 0, n_clear = 0, n_qen = 0, n_done = 0, n_err = 0, n_busy = 0;
  int a3_nz_at = 0, a3_nz_val = 0;
  logic [DW-1:0] prev_a3 = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_%0d outputs: dut=%h model=%h", cyc, got_v, exp_v);
      end
      n_sys   += int'(sys_enable);
      n_clear += int'(accum_clear);
      n_qen   += int'(quant_enable);
      n_done  += int'(done);
      n_err   += int'(err);
      n_busy  += int'(busy);
      if (a_out[3] != '0 && prev_a3 == '0) begin
        a3_nz_at  = n_sys;
        a3_nz_val = int'(a_out[3]);
      end
      prev_a3 = a_out[3];
    end
  end

  int b_sys, b_clear, b_qen, b_done, b_err, b_busy;

  task automatic snap();
    b_sys = n_sys; b_clear = n_clear; b_qen = n_qen; b_done = n_done; b_err = n_err; b_busy = n_busy;
  endtask

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (got_v !== '0) begin
      n_fail++;
      $display("FAIL %s: got %h want 0", name, got_v);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_sig(input int which, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int c = 0; c < budget && !hit; c++) begin
      tick();
      hit = (which == W_READY) ? s_ready : quant_enable;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_%s: got not-seen want seen within %0d cycles", name, budget);
    end
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit fixed, input bit toggle, input bit hold,
                      output int hs, output int cu);
    int b;
    b = 0; hs = 0; cu = 0;
    wait_sig(W_READY, 10, "ready");
    while (b < k && cu < 100) begin
      s_valid = toggle ? (cu % 2 == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        s_a[i] = fixed ? DW'(i + 1) : DW'(b * 16 + i + 1);
        s_b[i] = fixed ? DW'(i + 1) : DW'(200 - b * 7 - i);
      end
      if (s_valid && s_ready) begin hs++; b++; end
      tick();
      cu++;
    end
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic finish_job(input int delay, input string tag);
    int qc;
    wait_sig(W_QEN, 100, {tag, "_qen"});
    tick();
    s_valid = 1'b0;
    repeat (delay) tick();
    quant_valid = 1'b1;
    qc = cyc;
    tick();
    quant_valid = 1'b0;
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_done_latency"}, cyc - qc, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100us");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int hs, cu, c;
    bit seen;
    #1 reset_n = 1'b0;
    #2 check_zero("reset_outputs");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // k=3, constant {1,2,3,4} beats, s_valid held high
    snap();
    start_job(3);
    feed(3, 1, 0, 1, hs, cu);
    finish_job(0, "basic");
    check("basic_clear_cycles", n_clear - b_clear, 1);
    check("basic_sys_cycles", n_sys - b_sys, 10);
    check("basic_a3_first_nz_idx", a3_nz_at - b_sys, 4);
    check("basic_a3_first_nz_val", a3_nz_val, 4);
    check("basic_qen_cycles", n_qen - b_qen, 1);
    tick();

    // k=2 with a one-cycle stall between beats
    snap();
    start_job(2);
    feed(2, 0, 1, 0, hs, cu);
    check("stall_handshakes", hs, 2);
    check("stall_stream_cycles", cu, 3);
    finish_job(2, "stall");
    check("stall_sys_cycles", n_sys - b_sys, 9);
    tick();

    // illegal lengths 0 and 17
    snap();
    start_job(0);
    repeat (2) tick();
    start_job(17);
    repeat (2) tick();
    check("badk_err_pulses", n_err - b_err, 2);
    check("badk_busy_cycles", n_busy - b_busy, 0);
    check("badk_sys_cycles", n_sys - b_sys, 0);

    // reset during the 3rd flush step, then a k=1 job straight away
    snap();
    start_job(3);
    feed(3, 0, 0, 0, hs, cu);
    repeat (2) tick();
    reset_n = 1'b0;
    #1 check_zero("abort_outputs");
    tick();
    check("abort_no_done", n_done - b_done, 0);
    check("abort_no_err", n_err - b_err, 0);
    snap();
    reset_n = 1'b1;
    start_job(1);
    check("restart_clear", accum_clear, 1);
    check("restart_busy", busy, 1);
    feed(1, 0, 0, 0, hs, cu);
    finish_job(1, "restart");
    check("restart_sys_cycles", n_sys - b_sys, 8);
    check("restart_done_pulses", n_done - b_done, 1);
    tick();

    // quant_valid in STREAM is ignored; WAIT behaviour with quant_valid withheld
    snap();
    start_job(2);
    wait_sig(W_READY, 10, "qv_ready");
    s_valid = 1'b0;
    quant_valid = 1'b1;
    tick();
    quant_valid = 1'b0;
    check("qv_stream_busy", busy, 1);
    check("qv_stream_no_done", n_done - b_done, 0);
    feed(2, 0, 0, 0, hs, cu);
    wait_sig(W_QEN, 100, "to_qen");
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    seen = 0;
    c = 0;
    while (!seen && c < 100) begin
      tick();
      c++;
      seen = err;
    end
    check("timeout_err_latency", c, 65);
    check("timeout_no_done", n_done - b_done, 0);
    tick();
    check("timeout_idle", busy, 0);
`else
    repeat (80) tick();
    check("wait_no_err", n_err - b_err, 0);
    check("wait_no_done", n_done - b_done, 0);
    check("wait_still_busy", busy, 1);
    quant_valid = 1'b1;
    tick();
    quant_valid = 1'b0;
    check("wait_late_done", done, 1);
`endif
    tick();

    // start while busy must not disturb the running k=2 job
    snap();
    start_job(2);
    start = 1'b1;
    k_len = KW'(5);
    feed(2, 0, 0, 0, hs, cu);
    start = 1'b0;
    finish_job(0, "busystart");
    check("busystart_sys_cycles", n_sys - b_sys, 9);
    check("busystart_clear_cycles", n_clear - b_clear, 1);
    tick();
    check("busystart_idle", busy, 0);

    // maximum length job
    snap();
    start_job(16);
    feed(16, 0, 0, 0, hs, cu);
    finish_job(3, "kmax");
    check("kmax_sys_cycles", n_sys - b_sys, 23);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
